// File: rtl/hazard_pkg.sv
// Shared types and opcode constants for the RV32 hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_IDEX = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Returns {rs2_used, rs1_used}; LUI/AUIPC/JAL and unknown opcodes read no sources.
  function automatic logic [1:0] rs_used(input logic [31:0] instr);
    case (instr[6:0])
      OP_R, OP_STORE, OP_BRANCH: rs_used = 2'b11;
      OP_I, OP_LOAD, OP_JALR:    rs_used = 2'b01;
      default:                   rs_used = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_fwd_sel.sv
// EX-stage operand forward select: pure comparator, zero latency, no flow control.
// MEM result wins over WB; loads sitting in MEM are never forwarded from MEM.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_ex,
  input  logic              rd_wren_mem,
  input  logic [ADDR_W-1:0] rd_mem,
  input  logic              mem_ren_mem,
  input  logic              rd_wren_wb,
  input  logic [ADDR_W-1:0] rd_wb,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_IDEX;
    if (rd_wren_mem && (rd_mem != '0) && (rd_mem == rs_ex) && !mem_ren_mem) begin
      sel = FWD_MEM;
    end else if (rd_wren_wb && (rd_wb != '0) && (rd_wb == rs_ex)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: combinational stall/flush/forward, registered FSM for load-use and dmem freeze.
// A dmem wait freezes everything and defers flushes; optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W          = 5,
  parameter int LU_STALL_CYCLES = 1,
  parameter int MAX_WAIT        = 64,
  parameter int CNT_W           = $clog2(MAX_WAIT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_instr_id,
  input  logic [ADDR_W-1:0] i_rs1_addr_id,
  input  logic [ADDR_W-1:0] i_rs2_addr_id,
  input  logic              i_mem_ren_ex,
  input  logic [ADDR_W-1:0] i_rd_addr_ex,
  input  logic [ADDR_W-1:0] i_rs1_addr_ex,
  input  logic [ADDR_W-1:0] i_rs2_addr_ex,
  input  logic              i_rd_wren_mem,
  input  logic [ADDR_W-1:0] i_rd_addr_mem,
  input  logic              i_mem_ren_mem,
  input  logic              i_mem_req_mem,
  input  logic              i_dmem_ack,
  input  logic              i_rd_wren_wb,
  input  logic [ADDR_W-1:0] i_rd_addr_wb,
  input  logic              i_branch_taken,
  output logic              o_stall_pc,
  output logic              o_stall_if_id,
  output logic              o_stall_id_ex,
  output logic              o_stall_ex_mem,
  output logic              o_flush_if_id,
  output logic              o_flush_id_ex,
  output logic              o_flush_mem_wb,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b,
  output logic              o_mem_timeout,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
);

  localparam logic [2:0]       LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  hz_state_e        state_q;
  hz_state_e        ret_state_q;
  hz_state_e        eff_state;
  logic [2:0]       lu_cnt_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
  logic             mem_wait;
  logic             lu_hit;
  logic [1:0]       used;
  fwd_sel_e         fwd_a;
  fwd_sel_e         fwd_b;

  assign used     = rs_used(i_instr_id);
  assign mem_wait = i_mem_req_mem && !i_dmem_ack;
  assign lu_hit   = i_mem_ren_ex && (i_rd_addr_ex != '0) &&
                    ((used[0] && (i_rs1_addr_id == i_rd_addr_ex)) ||
                     (used[1] && (i_rs2_addr_id == i_rd_addr_ex)));

  // On the release cycle of a freeze, behave as the state that was frozen.
  assign eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs_ex       (i_rs1_addr_ex),
    .rd_wren_mem (i_rd_wren_mem),
    .rd_mem      (i_rd_addr_mem),
    .mem_ren_mem (i_mem_ren_mem),
    .rd_wren_wb  (i_rd_wren_wb),
    .rd_wb       (i_rd_addr_wb),
    .sel         (fwd_a)
  );

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs_ex       (i_rs2_addr_ex),
    .rd_wren_mem (i_rd_wren_mem),
    .rd_mem      (i_rd_addr_mem),
    .mem_ren_mem (i_mem_ren_mem),
    .rd_wren_wb  (i_rd_wren_wb),
    .rd_wb       (i_rd_addr_wb),
    .sel         (fwd_b)
  );

  assign o_forward_a   = i_rst_n ? fwd_a : FWD_IDEX;
  assign o_forward_b   = i_rst_n ? fwd_b : FWD_IDEX;
  assign o_mem_timeout = i_rst_n && (timeout_q || (mem_wait && (wait_cnt_q == WAIT_LAST)));

  always_comb begin
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_stall_ex_mem = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    o_flush_mem_wb = 1'b0;
    if (i_rst_n) begin
      if (mem_wait) begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_stall_id_ex  = 1'b1;
        o_stall_ex_mem = 1'b1;
        o_flush_mem_wb = 1'b1;
      end else if (i_branch_taken) begin
        // Wrong-path instructions are discarded, so any load-use stall is moot.
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end else if ((eff_state == LU_HOLD) || ((eff_state == RUN) && lu_hit)) begin
        o_stall_pc    = 1'b1;
        o_stall_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      lu_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else if (mem_wait) begin
      if (state_q != MEM_WAIT) begin
        ret_state_q <= state_q;
      end
      state_q <= MEM_WAIT;
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (wait_cnt_q >= WAIT_LAST) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
      if (i_branch_taken) begin
        state_q  <= RUN;
        lu_cnt_q <= '0;
      end else begin
        case (eff_state)
          LU_HOLD: begin
            if (lu_cnt_q <= 3'd1) begin
              state_q  <= RUN;
              lu_cnt_q <= '0;
            end else begin
              state_q  <= LU_HOLD;
              lu_cnt_q <= lu_cnt_q - 1'b1;
            end
          end
          default: begin
            if (lu_hit && (LU_STALL_CYCLES > 1)) begin
              state_q  <= LU_HOLD;
              lu_cnt_q <= LU_RELOAD;
            end else begin
              state_q <= RUN;
            end
          end
        endcase
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_stall_pc) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (o_flush_if_id) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: instance a (1-cycle load-use, MAX_WAIT 64)
// and instance b (3-cycle load-use, MAX_WAIT 4) share one set of inputs.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_LU   = 7'b1100010;
  localparam logic [6:0] CTL_MW   = 7'b1111001;
  localparam logic [6:0] CTL_BR   = 7'b0000110;
  localparam logic [31:0] I_ADD   = 32'h0000_0033;
  localparam logic [31:0] I_ADDI  = 32'h0000_0013;
  localparam logic [31:0] I_LUI   = 32'h0000_0037;
  localparam logic [31:0] I_STORE = 32'h0000_0023;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_instr_id;
  logic [4:0]  i_rs1_addr_id, i_rs2_addr_id, i_rd_addr_ex, i_rs1_addr_ex, i_rs2_addr_ex;
  logic [4:0]  i_rd_addr_mem, i_rd_addr_wb;
  logic        i_mem_ren_ex, i_rd_wren_mem, i_mem_ren_mem, i_mem_req_mem, i_dmem_ack;
  logic        i_rd_wren_wb, i_branch_taken;

  logic        a_spc, a_sifid, a_sidex, a_sexmem, a_fifid, a_fidex, a_fmemwb, a_tmo;
  logic        b_spc, b_sifid, b_sidex, b_sexmem, b_fifid, b_fidex, b_fmemwb, b_tmo;
  logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [6:0]  a_ctl, b_ctl;

  assign a_ctl = {a_spc, a_sifid, a_sidex, a_sexmem, a_fifid, a_fidex, a_fmemwb};
  assign b_ctl = {b_spc, b_sifid, b_sidex, b_sexmem, b_fifid, b_fidex, b_fmemwb};

  int n_chk = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  hazard_stall_ctrl #(.ADDR_W(5), .LU_STALL_CYCLES(1), .MAX_WAIT(64)) u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr_id(i_instr_id),
    .i_rs1_addr_id(i_rs1_addr_id), .i_rs2_addr_id(i_rs2_addr_id),
    .i_mem_ren_ex(i_mem_ren_ex), .i_rd_addr_ex(i_rd_addr_ex),
    .i_rs1_addr_ex(i_rs1_addr_ex), .i_rs2_addr_ex(i_rs2_addr_ex),
    .i_rd_wren_mem(i_rd_wren_mem), .i_rd_addr_mem(i_rd_addr_mem),
    .i_mem_ren_mem(i_mem_ren_mem), .i_mem_req_mem(i_mem_req_mem), .i_dmem_ack(i_dmem_ack),
    .i_rd_wren_wb(i_rd_wren_wb), .i_rd_addr_wb(i_rd_addr_wb), .i_branch_taken(i_branch_taken),
    .o_stall_pc(a_spc), .o_stall_if_id(a_sifid), .o_stall_id_ex(a_sidex),
    .o_stall_ex_mem(a_sexmem), .o_flush_if_id(a_fifid), .o_flush_id_ex(a_fidex),
    .o_flush_mem_wb(a_fmemwb), .o_forward_a(a_fwd_a), .o_forward_b(a_fwd_b),
    .o_mem_timeout(a_tmo), .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt)
  );

  hazard_stall_ctrl #(.ADDR_W(5), .LU_STALL_CYCLES(3), .MAX_WAIT(4)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr_id(i_instr_id),
    .i_rs1_addr_id(i_rs1_addr_id), .i_rs2_addr_id(i_rs2_addr_id),
    .i_mem_ren_ex(i_mem_ren_ex), .i_rd_addr_ex(i_rd_addr_ex),
    .i_rs1_addr_ex(i_rs1_addr_ex), .i_rs2_addr_ex(i_rs2_addr_ex),
    .i_rd_wren_mem(i_rd_wren_mem), .i_rd_addr_mem(i_rd_addr_mem),
    .i_mem_ren_mem(i_mem_ren_mem), .i_mem_req_mem(i_mem_req_mem), .i_dmem_ack(i_dmem_ack),
    .i_rd_wren_wb(i_rd_wren_wb), .i_rd_addr_wb(i_rd_addr_wb), .i_branch_taken(i_branch_taken),
    .o_stall_pc(b_spc), .o_stall_if_id(b_sifid), .o_stall_id_ex(b_sidex),
    .o_stall_ex_mem(b_sexmem), .o_flush_if_id(b_fifid), .o_flush_id_ex(b_fidex),
    .o_flush_mem_wb(b_fmemwb), .o_forward_a(b_fwd_a), .o_forward_b(b_fwd_b),
    .o_mem_timeout(b_tmo), .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    i_instr_id = I_LUI;
    i_rs1_addr_id = '0; i_rs2_addr_id = '0;
    i_mem_ren_ex = 1'b0; i_rd_addr_ex = '0; i_rs1_addr_ex = '0; i_rs2_addr_ex = '0;
    i_rd_wren_mem = 1'b0; i_rd_addr_mem = '0; i_mem_ren_mem = 1'b0;
    i_mem_req_mem = 1'b0; i_dmem_ack = 1'b0;
    i_rd_wren_wb = 1'b0; i_rd_addr_wb = '0; i_branch_taken = 1'b0;
  endtask

  // Load x5 in EX, ADD x6,x5,x7 in ID.
  task automatic load_use();
    idle();
    i_mem_ren_ex = 1'b1; i_rd_addr_ex = 5'd5;
    i_instr_id = I_ADD; i_rs1_addr_id = 5'd5; i_rs2_addr_id = 5'd7;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset held with every hazard source active: outputs must stay quiet.
    load_use();
    i_rd_wren_mem = 1'b1; i_rd_addr_mem = 5'd3; i_rs1_addr_ex = 5'd3;
    i_mem_req_mem = 1'b1; i_branch_taken = 1'b1;
    #2;
    chk("rst_ctl_a", 32'(a_ctl), 32'(CTL_NONE));
    chk("rst_ctl_b", 32'(b_ctl), 32'(CTL_NONE));
    chk("rst_fwd_a", 32'(a_fwd_a), 32'd0);
    chk("rst_tmo", 32'(a_tmo), 32'd0);
    chk("rst_scnt", a_scnt, 32'd0);
    chk("rst_fcnt", b_fcnt, 32'd0);
    tick();
    idle();
    i_rst_n = 1'b1;
    #1;
    chk("idle_ctl", 32'(a_ctl), 32'(CTL_NONE));
    tick();

    // Load-use: one bubble for a, three for b.
    load_use();
    #1;
    chk("lu_hit_a", 32'(a_ctl), 32'(CTL_LU));
    chk("lu_hit_b", 32'(b_ctl), 32'(CTL_LU));
    tick();
    idle();
    i_rs1_addr_ex = 5'd5; i_rs2_addr_ex = 5'd7;
    i_rd_wren_wb = 1'b1; i_rd_addr_wb = 5'd5;
    i_instr_id = I_ADDI; i_rs1_addr_id = 5'd2;
    #1;
    chk("lu1_release", 32'(a_ctl), 32'(CTL_NONE));
    chk("lu1_fwd_a_wb", 32'(a_fwd_a), 32'd2);
    chk("lu1_fwd_b_rf", 32'(a_fwd_b), 32'd0);
    chk("lu3_hold1", 32'(b_ctl), 32'(CTL_LU));
    tick();
    chk("lu3_hold2", 32'(b_ctl), 32'(CTL_LU));
    chk("lu1_quiet", 32'(a_ctl), 32'(CTL_NONE));
    tick();
    chk("lu3_done", 32'(b_ctl), 32'(CTL_NONE));
    chk("lu3_fwd_a_wb", 32'(b_fwd_a), 32'd2);

    // Forwarding priority and x0 guard.
    idle();
    i_rs2_addr_ex = 5'd3;
    i_rd_wren_mem = 1'b1; i_rd_addr_mem = 5'd3;
    i_rd_wren_wb = 1'b1; i_rd_addr_wb = 5'd3;
    #1 chk("fwd_b_mem", 32'(a_fwd_b), 32'd1);
    i_rd_addr_mem = 5'd0;
    #1 chk("fwd_b_mem_x0", 32'(a_fwd_b), 32'd2);
    i_rd_addr_mem = 5'd3; i_mem_ren_mem = 1'b1;
    #1 chk("fwd_b_load_mem", 32'(a_fwd_b), 32'd2);
    i_rd_wren_wb = 1'b0;
    #1 chk("fwd_b_none", 32'(a_fwd_b), 32'd0);
    i_rs1_addr_ex = 5'd4; i_rd_addr_mem = 5'd4; i_mem_ren_mem = 1'b0;
    #1 chk("fwd_a_mem", 32'(a_fwd_a), 32'd1);
    i_rs2_addr_ex = 5'd0; i_rd_addr_mem = 5'd0; i_rd_wren_wb = 1'b1; i_rd_addr_wb = 5'd0;
    #1 chk("fwd_b_x0", 32'(a_fwd_b), 32'd0);
    tick();

    // dmem wait with a pending branch; b times out on its 4th wait cycle.
    idle();
    i_mem_req_mem = 1'b1; i_mem_ren_mem = 1'b1; i_rd_wren_mem = 1'b1; i_rd_addr_mem = 5'd8;
    i_branch_taken = 1'b1;
    i_rs1_addr_ex = 5'd9; i_rd_wren_wb = 1'b1; i_rd_addr_wb = 5'd9;
    for (int i = 1; i <= 6; i++) begin
      #1;
      chk("mw_ctl_a", 32'(a_ctl), 32'(CTL_MW));
      chk("mw_ctl_b", 32'(b_ctl), 32'(CTL_MW));
      chk("mw_fwd_a", 32'(a_fwd_a), 32'd2);
      chk("mw_tmo_b", 32'(b_tmo), 32'(i >= 4));
      chk("mw_tmo_a", 32'(a_tmo), 32'd0);
      tick();
    end
    i_dmem_ack = 1'b1;
    #1;
    chk("ack_flush_a", 32'(a_ctl), 32'(CTL_BR));
    chk("ack_flush_b", 32'(b_ctl), 32'(CTL_BR));
    tick();
    idle();
    #1;
    chk("after_ack", 32'(a_ctl), 32'(CTL_NONE));
    chk("tmo_sticky1", 32'(b_tmo), 32'd1);
    tick();
    chk("tmo_sticky2", 32'(b_tmo), 32'd1);

    // Branch during LU_HOLD clears the hold; branch beats a same-cycle load-use.
    load_use();
    #1 chk("br_pre_lu", 32'(b_ctl), 32'(CTL_LU));
    tick();
    idle();
    i_branch_taken = 1'b1;
    #1;
    chk("br_in_hold_b", 32'(b_ctl), 32'(CTL_BR));
    chk("br_in_hold_a", 32'(a_ctl), 32'(CTL_BR));
    tick();
    idle();
    #1 chk("hold_cleared", 32'(b_ctl), 32'(CTL_NONE));
    load_use();
    i_branch_taken = 1'b1;
    #1 chk("br_vs_lu", 32'(a_ctl), 32'(CTL_BR));
    tick();
    idle();
    #1 chk("br_vs_lu_after", 32'(b_ctl), 32'(CTL_NONE));
    tick();

    // dmem wait during LU_HOLD freezes the bubble count.
    load_use();
    #1 chk("frz_lu", 32'(b_ctl), 32'(CTL_LU));
    tick();
    idle();
    i_mem_req_mem = 1'b1;
    #1 chk("frz_mw1", 32'(b_ctl), 32'(CTL_MW));
    tick();
    chk("frz_mw2", 32'(b_ctl), 32'(CTL_MW));
    tick();
    i_dmem_ack = 1'b1;
    #1;
    chk("frz_resume1", 32'(b_ctl), 32'(CTL_LU));
    chk("frz_resume_a", 32'(a_ctl), 32'(CTL_NONE));
    tick();
    idle();
    #1 chk("frz_resume2", 32'(b_ctl), 32'(CTL_LU));
    tick();
    chk("frz_end", 32'(b_ctl), 32'(CTL_NONE));

    // Reset asserted mid-hold.
    load_use();
    tick();
    i_rs1_addr_ex = 5'd5; i_rd_wren_wb = 1'b1; i_rd_addr_wb = 5'd5;
    i_rst_n = 1'b0;
    #1;
    chk("rst_hold_b", 32'(b_ctl), 32'(CTL_NONE));
    chk("rst_hold_a", 32'(a_ctl), 32'(CTL_NONE));
    chk("rst_hold_fwd", 32'(b_fwd_a), 32'd0);
    chk("rst_hold_tmo", 32'(b_tmo), 32'd0);
    tick();
    idle();
    i_rst_n = 1'b1;
    i_mem_ren_ex = 1'b1; i_rd_addr_ex = 5'd5; i_rs1_addr_id = 5'd5;
    #1 chk("post_rst_lui", 32'(b_ctl), 32'(CTL_NONE));
    tick();

    // rs-usage decode.
    i_instr_id = I_ADDI; i_rs1_addr_id = 5'd6; i_rs2_addr_id = 5'd5;
    #1 chk("addi_rs2_unused", 32'(a_ctl), 32'(CTL_NONE));
    i_instr_id = I_ADD; i_rd_addr_ex = 5'd0; i_rs1_addr_id = 5'd0;
    #1 chk("rd_x0", 32'(a_ctl), 32'(CTL_NONE));
    i_instr_id = I_STORE; i_rd_addr_ex = 5'd5; i_rs1_addr_id = 5'd1; i_rs2_addr_id = 5'd5;
    #1 chk("store_rs2", 32'(a_ctl), 32'(CTL_LU));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Second-generation hazard/forwarding controller for the 5-stage RV32 pipeline.
- Provides EX-stage forwarding select, multi-cycle load-use stall, data-memory wait-state freeze, and branch flush.
- Register-addressing width, load-use penalty and memory timeout are parametrised.
- Sits beside the pipeline registers and drives their stall/flush enables.

Parameters:
- ADDR_W, 5, register address width (4 for RV32E).
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..4.
- MAX_WAIT, 64, dmem wait cycles before o_mem_timeout is raised; must be ≥2.
- CNT_W, $clog2(MAX_WAIT+1), width of the internal wait counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_instr_id  in  32  ID instruction; opcode decides rs1/rs2 usage.
- i_rs1_addr_id  in  ADDR_W  ID rs1.
- i_rs2_addr_id  in  ADDR_W  ID rs2.
- i_mem_ren_ex  in  1  EX instruction is a load.
- i_rd_addr_ex  in  ADDR_W  EX rd.
- i_rs1_addr_ex  in  ADDR_W  EX rs1.
- i_rs2_addr_ex  in  ADDR_W  EX rs2.
- i_rd_wren_mem  in  1  MEM writes rd.
- i_rd_addr_mem  in  ADDR_W  MEM rd.
- i_mem_ren_mem  in  1  MEM is a load; its data is not forwardable from MEM.
- i_mem_req_mem  in  1  MEM holds a load/store access.
- i_dmem_ack  in  1  dmem access complete this cycle.
- i_rd_wren_wb  in  1  WB writes rd.
- i_rd_addr_wb  in  ADDR_W  WB rd.
- i_branch_taken  in  1  EX redirect.
- o_stall_pc  out  1  hold PC.
- o_stall_if_id  out  1  hold IF/ID.
- o_stall_id_ex  out  1  hold ID/EX.
- o_stall_ex_mem  out  1  hold EX/MEM.
- o_flush_if_id  out  1  bubble IF/ID.
- o_flush_id_ex  out  1  bubble ID/EX.
- o_flush_mem_wb  out  1  bubble MEM/WB.
- o_forward_a  out  2  00 ID/EX, 01 MEM, 10 WB.
- o_forward_b  out  2  same encoding for rs2.
- o_mem_timeout  out  1  sticky dmem timeout flag.
- o_stall_cnt  out  32  perf counter (optional feature).
- o_flush_cnt  out  32  perf counter (optional feature).

Behaviour:
- Reset is asynchronous and active-low: state RUN, counters 0, o_mem_timeout 0. Every stall/flush output reads 0 and forward selects read 00 while i_rst_n is low.
- rs-usage decode:
  - R-type, store, branch: rs1 and rs2 used.
  - I-ALU, load, JALR: rs1 only.
  - Everything else (LUI, AUIPC, JAL): neither used.
- Load-use hit (lu_hit): i_mem_ren_ex, and rd_ex≠0, and a used rs_id equals rd_ex.
- Forwarding, per operand (combinational):
  - 01 when i_rd_wren_mem, rd_mem≠0, rd_mem==rs_ex, and !i_mem_ren_mem.
  - Otherwise 10 when i_rd_wren_wb, rd_wb≠0, rd_wb==rs_ex.
  - Otherwise 00.
  - MEM has priority over WB.
- FSM states: RUN, LU_HOLD, MEM_WAIT.
- mem_wait condition: i_mem_req_mem && !i_dmem_ack. It overrides everything:
  - o_stall_pc, o_stall_if_id, o_stall_id_ex and o_stall_ex_mem all 1.
  - o_flush_mem_wb 1.
  - o_flush_if_id and o_flush_id_ex 0; a branch in EX is held and flushes only when the freeze releases.
  - Forwarding still computed.
- RUN:
  - On lu_hit: o_stall_pc=o_stall_if_id=o_flush_id_ex=1 this cycle.
  - If LU_STALL_CYCLES>1, go to LU_HOLD with the hold counter set to LU_STALL_CYCLES-1.
- LU_HOLD:
  - Repeats the load-use outputs each cycle and decrements the counter.
  - Returns to RUN on the cycle the counter reaches 1. Total bubbles = LU_STALL_CYCLES.
  - mem_wait freezes the counter and state without consuming a bubble.
- MEM_WAIT:
  - Entered from any state when mem_wait is true.
  - The wait counter increments each waiting cycle, saturating at MAX_WAIT. Reaching MAX_WAIT sets o_mem_timeout until reset. The freeze continues.
  - On ack, return to the saved state (RUN or LU_HOLD); the wait counter clears.
- Branch with no mem_wait: o_flush_if_id=1 and o_flush_id_ex=1.
  - A branch in EX cannot coexist with a load-use stall.
  - If both fire, the flush wins and the LU_HOLD counter clears to RUN; the stalled instruction is on the wrong path.
- Reset mid-stall: immediate return to RUN, no residual bubbles.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - o_stall_cnt increments on any cycle where o_stall_pc=1.
  - o_flush_cnt increments on any cycle where o_flush_if_id=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef fwd_sel_e (FWD_IDEX=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10).
  - typedef hz_state_e (RUN, LU_HOLD, MEM_WAIT).
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR).
- One sub-module, fwd_sel: pure comparator instantiated twice, for rs1 and rs2.

Test Plan:
- Load x5 in EX, ADD x6,x5,x7 in ID, LU_STALL_CYCLES=1 -> o_stall_pc/o_stall_if_id/o_flush_id_ex=1 for exactly 1 cycle. Next cycle: o_forward_a=10.
- Same stimulus with LU_STALL_CYCLES=3 -> 3 consecutive stall cycles, then RUN. Forwarding from WB or regfile is correct afterwards.
- MEM=ADDI x3 (wren), WB=ADDI x3, EX rs2=x3 -> o_forward_b=01. With rd_mem=x0 -> 10. With a load in MEM -> 10.
- Load in MEM, i_dmem_ack low 5 cycles -> all four stalls=1 and o_flush_mem_wb=1 for 5 cycles. i_branch_taken high meanwhile -> no flush until ack, then flush 1 cycle.
- MAX_WAIT=4, ack withheld 6 cycles -> o_mem_timeout rises on the 4th wait cycle and stays 1 until i_rst_n low.
- i_rst_n asserted during LU_HOLD (count 2) -> all outputs 0 immediately. After release, the next unrelated instruction sees no stall.
